// File: rtl/seven_seg_scan_mux_pkg.sv
// Shared types and the leading-zero blanking rule for the seven-segment scanner.
package seg_pkg;
    localparam int DIGITS_DEFAULT = 4;
    localparam int MAX_DIGITS     = 8;

    typedef logic [3:0] nibble_t;

    // Callers zero-extend a narrower shadow, so the unused upper nibbles read as zero.
    function automatic logic digit_blank(input logic [4*MAX_DIGITS-1:0] shadow,
                                         input int k, input logic en);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++)
            if (i >= k && shadow[4*i +: 4] != 4'h0) nz = 1'b1;
        return en && (k != 0) && !nz;
    endfunction
endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// Value/strobe in, per-slot digit drive out, between the scanner and its neighbours.
interface seven_seg_scan_mux_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = DIGITS_DEFAULT
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value;
    logic                    value_valid;
    logic                    blank_lz;
    nibble_t                 nibble;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_start;

    modport master (
        output value, value_valid, blank_lz,
        input  nibble, an_n, digit_idx, frame_start
    );

    modport slave (
        input  value, value_valid, blank_lz,
        output nibble, an_n, digit_idx, frame_start
    );
endinterface

// File: rtl/seven_seg_scan_mux_clk_en_div.sv
// Free-running divider giving a one-cycle enable at OUT_HZ; also usable for the LFSR step rate.
module clk_en_div #(
    parameter int CLK_HZ = 100_000_000,
    parameter int OUT_HZ = 4_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int DIV = CLK_HZ / OUT_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("clk_en_div: CLK_HZ/OUT_HZ must be at least 2");
    end
    if (CLK_HZ % OUT_HZ != 0) begin : g_bad_ratio
        $error("clk_en_div: CLK_HZ must be an integer multiple of OUT_HZ");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/seven_seg_scan_mux.sv
// Common-anode digit scanner: one nibble and one active-low anode per slot, with the
// displayed value swapped only at frame wrap so a frame never mixes two values.
module seven_seg_scan_mux
    import seg_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SLOT_HZ    = 4_000,
    parameter int NUM_DIGITS = DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scan_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("seven_seg_scan_mux: NUM_DIGITS must be 1..8");
    end

    logic tick;

    clk_en_div #(
        .CLK_HZ (CLK_HZ),
        .OUT_HZ (SLOT_HZ)
    ) u_slot_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    nibble_t [NUM_DIGITS-1:0] pending, shadow, shadow_next;
    logic    [IDX_W-1:0]      idx, k_next;
    logic                     wrap, blank;

    always_comb begin
        wrap        = tick && (idx == LAST_IDX);
        k_next      = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        shadow_next = shadow;
        // A strobe landing on the wrap edge bypasses pending so it shows this frame.
        if (wrap) shadow_next = bus.value_valid ? bus.value : pending;
        blank = digit_blank(32'(shadow_next), int'(k_next), bus.blank_lz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= LAST_IDX;
            pending         <= '0;
            shadow          <= '0;
            bus.nibble      <= '0;
            bus.an_n        <= '1;
            bus.frame_start <= 1'b0;
        end else begin
            if (bus.value_valid) pending <= bus.value;
            shadow          <= shadow_next;
            bus.frame_start <= 1'b0;
            if (tick) begin
                idx             <= k_next;
                bus.nibble      <= blank ? nibble_t'(0) : shadow_next[k_next];
                bus.an_n        <= blank ? '1 : ~(NUM_DIGITS'(1) << k_next);
                bus.frame_start <= (k_next == '0);
            end
        end
    end

    assign bus.digit_idx = idx;
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a time-since-reset display model.
module tb_seven_seg_scan_mux;
    localparam int CLK_HZ  = 16;
    localparam int SLOT_HZ = 4;
    localparam int DIV     = CLK_HZ / SLOT_HZ;
    localparam int N       = 4;

    logic clk;
    logic rst_n;

    seven_seg_scan_mux_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_mux #(
        .CLK_HZ     (CLK_HZ),
        .SLOT_HZ    (SLOT_HZ),
        .NUM_DIGITS (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Model: edges since reset decide the slot; the value shown in a frame is the last
    // strobe seen at or before that frame's first edge.
    int          m_t = 0;
    logic [15:0] m_pend = '0, m_shown = '0;
    logic [3:0]  e_nib = '0, e_an = 4'hF;
    logic [1:0]  e_idx = 2'd3;
    logic        e_fs = 1'b0;

    int          m_tn, m_k;
    logic [15:0] m_p, m_sh, m_tail;
    logic        m_bl;

    always_comb begin
        m_tn   = m_t + 1;
        m_p    = bus.value_valid ? bus.value : m_pend;
        m_k    = (m_tn / DIV + N - 1) % N;
        m_sh   = (m_k == 0) ? m_p : m_shown;
        m_tail = m_sh >> (4 * m_k);
        m_bl   = bus.blank_lz && (m_k != 0) && (m_tail == 16'h0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_pend <= '0; m_shown <= '0;
            e_nib <= '0; e_an <= 4'hF; e_idx <= 2'd3; e_fs <= 1'b0;
        end else begin
            m_t    <= m_tn;
            m_pend <= m_p;
            e_fs   <= 1'b0;
            if (m_tn % DIV == 0) begin
                e_idx <= 2'(m_k);
                e_nib <= m_bl ? 4'h0 : m_tail[3:0];
                e_an  <= m_bl ? 4'hF : ~(4'b0001 << m_k);
                e_fs  <= (m_k == 0);
                if (m_k == 0) m_shown <= m_p;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_nibble",      32'(bus.nibble),      32'(e_nib));
        chk("model_an_n",        32'(bus.an_n),        32'(e_an));
        chk("model_digit_idx",   32'(bus.digit_idx),   32'(e_idx));
        chk("model_frame_start", 32'(bus.frame_start), 32'(e_fs));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] v);
        bus.value       = v;
        bus.value_valid = 1'b1;
        step(1);
        bus.value_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.frame_start && n < 40);
        chk("wait_frame_start", 32'(bus.frame_start), 32'd1);
    endtask

    task automatic release_check();
        for (int i = 0; i < DIV - 1; i++) begin
            step(1);
            chk("dark_an_n", 32'(bus.an_n), 32'hF);
        end
        step(1);
        chk("first_an_n",   32'(bus.an_n),        32'hE);
        chk("first_nibble", 32'(bus.nibble),      32'h0);
        chk("first_idx",    32'(bus.digit_idx),   32'h0);
        chk("first_fs",     32'(bus.frame_start), 32'h1);
    endtask

    logic [3:0] lit_nib [4];
    logic [3:0] lit_an  [4];

    initial begin
        int n;
        rst_n           = 1'b0;
        bus.value       = '0;
        bus.value_valid = 1'b0;
        bus.blank_lz    = 1'b0;
        step(3);
        chk("reset_an_n", 32'(bus.an_n), 32'hF);
        chk("reset_idx",  32'(bus.digit_idx), 32'h3);
        rst_n = 1'b1;
        release_check();

        // 1A3F over two frames
        lit_nib = '{4'hF, 4'h3, 4'hA, 4'h1};
        lit_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        pulse(16'h1A3F);
        wait_fs();
        for (int f = 0; f < 2; f++)
            for (int j = 0; j < N; j++) begin
                chk("scan_nibble", 32'(bus.nibble), 32'(lit_nib[j]));
                chk("scan_an_n",   32'(bus.an_n),   32'(lit_an[j]));
                step(DIV);
            end
        n = 1;
        while (!bus.frame_start && n < 40) begin
            step(1);
            n++;
        end
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.frame_start && n < 40);
        chk("frame_period", 32'(n), 32'd16);

        // mid-frame strobe waits for the next frame
        step(DIV);
        pulse(16'h1234);
        step(DIV - 1);
        chk("tear_old_d2", 32'(bus.nibble), 32'hA);
        step(DIV);
        chk("tear_old_d3", 32'(bus.nibble), 32'h1);
        step(DIV);
        chk("tear_new_d0", 32'(bus.nibble), 32'h4);
        chk("tear_new_fs", 32'(bus.frame_start), 32'h1);

        // leading-zero blanking
        bus.blank_lz = 1'b1;
        pulse(16'h0050);
        wait_fs();
        chk("lz_d0_an", 32'(bus.an_n), 32'hE);
        chk("lz_d0_nib", 32'(bus.nibble), 32'h0);
        step(DIV);
        chk("lz_d1_an", 32'(bus.an_n), 32'hD);
        chk("lz_d1_nib", 32'(bus.nibble), 32'h5);
        step(DIV);
        chk("lz_d2_an", 32'(bus.an_n), 32'hF);
        chk("lz_d2_nib", 32'(bus.nibble), 32'h0);
        step(DIV);
        chk("lz_d3_an", 32'(bus.an_n), 32'hF);
        pulse(16'h0000);
        wait_fs();
        chk("zero_d0_an", 32'(bus.an_n), 32'hE);
        chk("zero_d0_nib", 32'(bus.nibble), 32'h0);
        step(DIV);
        chk("zero_d1_an", 32'(bus.an_n), 32'hF);

        // strobe on the exact wrap edge
        bus.blank_lz = 1'b0;
        wait_fs();
        step(N * DIV - 1);
        bus.value       = 16'hBEEF;
        bus.value_valid = 1'b1;
        step(1);
        bus.value_valid = 1'b0;
        chk("wrap_fs", 32'(bus.frame_start), 32'h1);
        chk("wrap_d0", 32'(bus.nibble), 32'hF);
        step(DIV);
        chk("wrap_d1", 32'(bus.nibble), 32'hE);
        step(DIV);
        chk("wrap_d2", 32'(bus.nibble), 32'hE);
        step(DIV);
        chk("wrap_d3", 32'(bus.nibble), 32'hB);

        // async reset mid-frame at digit 2
        wait_fs();
        step(2 * DIV + 1);
        chk("pre_rst_idx", 32'(bus.digit_idx), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_an",  32'(bus.an_n),      32'hF);
        chk("async_rst_idx", 32'(bus.digit_idx), 32'h3);
        chk("async_rst_nib", 32'(bus.nibble),    32'h0);
        step(1);
        rst_n = 1'b1;
        release_check();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 2000; c++) begin
            bus.value_valid = ($urandom_range(0, 7) == 0);
            bus.value       = 16'($urandom >> (4 * $urandom_range(0, 4) + 16));
            if ($urandom_range(0, 63) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end else begin
                step(1);
            end
        end
        bus.value_valid = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_mux.md
Name: seven_seg_scan_mux

Overview:
- Time-multiplexed scanner for the board's common-anode multi-digit seven-segment display.
- Takes a packed hex value, for example the pseudo-random number generator output. Each scan slot it presents one 4-bit nibble to the hex-to-segment decoder and drives the matching active-low anode.
- Includes tear-free value update at frame boundaries and optional leading-zero blanking.
- Sits directly upstream of the segment decoder; the top level wires nibble to the decoder and an_n to the board pins.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- SLOT_HZ, 4_000, digit-switch rate in Hz. Each digit is lit for 1/SLOT_HZ s; frame rate is SLOT_HZ/NUM_DIGITS.
- NUM_DIGITS, 4, number of digits (1..8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  hex value to display; nibble 0 is the rightmost digit.
- value_valid  in  1  single-cycle strobe; captures value.
- blank_lz  in  1  level; 1 enables leading-zero blanking.
- nibble  out  4  nibble for the current digit, to the decoder input.
- an_n  out  NUM_DIGITS  anode enables, active low, one-hot-low or all ones.
- digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the lit digit.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- DIV = CLK_HZ/SLOT_HZ.
  - Elaboration-time assertion: DIV ≥ 2.
  - Elaboration-time assertion: CLK_HZ % SLOT_HZ == 0.
- Reset (asynchronous, all outputs registered):
  - div_cnt=0, digit_idx=NUM_DIGITS-1.
  - pending=0, shadow=0.
  - nibble=0, an_n=all ones, frame_start=0.
- Divider: div_cnt counts 0..DIV-1 and wraps. tick is asserted when div_cnt==DIV-1.
- On tick:
  - digit_idx advances modulo NUM_DIGITS.
  - The first tick after reset moves idx to 0, so the display is dark for exactly DIV cycles after reset.
- Capture: value_valid loads pending <= value on any cycle. A later strobe overwrites an earlier one; last write wins.
- Frame boundary (tick with digit_idx==NUM_DIGITS-1, i.e. wrap to 0):
  - shadow <= pending.
  - If value_valid is asserted in the same cycle, shadow <= value directly and pending <= value. The new value is shown in that frame.
- Output update happens on the same clock edge as the idx change. With k = the new idx:
  - nibble <= shadow_next[4k+3:4k], where shadow_next is the value shadow takes on that edge.
  - an_n <= ~(1<<k), unless digit k is blanked, in which case an_n <= all ones and nibble <= 0.
  - frame_start <= 1 when k==0, else 0.
- Blanking rule: digit k is blanked iff all of the following hold:
  - blank_lz is 1,
  - k ≠ 0,
  - every nibble k..NUM_DIGITS-1 of shadow_next is 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- blank_lz is sampled at each tick. A change takes effect from the next slot, not mid-slot.
- Between ticks all outputs hold. There are no glitches on an_n; exactly zero or one anode is low at any time.
- Reset mid-frame returns immediately to the reset state and drops pending data.
- Latency from value_valid to display is at most NUM_DIGITS*DIV cycles plus 1 edge.

Decomposition:
- Package seg_pkg: localparam DIGITS_DEFAULT=4, typedef logic [3:0] nibble_t, and function digit_blank(shadow, k, en) implementing the blanking rule.
- Sub-module clk_en_div (params CLK_HZ, OUT_HZ) producing a one-cycle tick. It is reusable for the LFSR step rate.
- The decoder is instantiated by the top level, not inside this block.

Test Plan:
- Reset, then release with CLK_HZ=16, SLOT_HZ=4 (DIV=4) → an_n=4'b1111 for 4 cycles. Then idx=0, an_n=4'b1110, nibble=0, frame_start pulses once.
- value_valid with 16'h1A3F, blank_lz=0, run 2 frames → nibble sequence F,3,A,1 with an_n 1110,1101,1011,0111, repeating. frame_start occurs every 16 cycles.
- Strobe 16'h1234 mid-frame (idx=1) → rest of the frame still shows the old shadow; the next frame shows 4,3,2,1.
- blank_lz=1, value 16'h0050 → digits 0,1 lit (0,5); slots 2,3 have an_n=1111 and nibble=0. Value 16'h0000 → only digit 0 lit with "0".
- value_valid with 16'hBEEF on the exact wrap tick → the frame starting on that edge shows F,E,E,B, with no frame of stale data.
- Assert rst_n=0 for 1 cycle at idx=2 → outputs reset asynchronously the same cycle; the restart sequence matches scenario 1.
